// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with parallel Gray load, sticky overflow/underflow flags and a wrap strobe.
// Latency: an input sampled at rising edge N is visible on every output after edge N. All outputs are flops.
// Backpressure: none. The counter accepts a command on every clock, and reset aborts it asynchronously.
module gray_updown_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_gray_i,
    input  logic             clear_flags_i,
    output logic [WIDTH-1:0] output_o,
    output logic [WIDTH-1:0] binary_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] MAX_V = '1;

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gry_q, gry_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrp_q, wrp_d;

    // Next-state selection. Load beats count, and count beats hold. A flag set by a wrap beats the clear.
    always_comb begin
        bin_d = bin_q;
        ovf_d = ovf_q & ~clear_flags_i;
        unf_d = unf_q & ~clear_flags_i;
        wrp_d = 1'b0;
        if (load_i) begin
            bin_d = gray2bin(load_gray_i);
        end else if (en_i) begin
            if (up_i) begin
                bin_d = bin_q + ONE;
                if (bin_q == MAX_V) begin
                    ovf_d = 1'b1;
                    wrp_d = 1'b1;
                end
            end else begin
                bin_d = bin_q - ONE;
                if (bin_q == ZERO) begin
                    unf_d = 1'b1;
                    wrp_d = 1'b1;
                end
            end
        end
        // A load takes the Gray value verbatim. Otherwise the Gray value is re-encoded from the next binary count.
        gry_d = load_i ? load_gray_i : bin2gray(bin_d);
    end

    // State registers. Reset clears everything immediately and also kills any pending wrap pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bin_q <= '0;
            gry_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            wrp_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            gry_q <= gry_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            wrp_q <= wrp_d;
        end
    end

    assign output_o    = gry_q;
    assign binary_o    = bin_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign wrap_o      = wrp_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter, covering a WIDTH=4 instance and a WIDTH=3 instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Reset is also asserted between edges to check the asynchronous clear.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b0, up_i = 1'b0, load_i = 1'b0, clear_flags_i = 1'b0;
    logic [3:0] load_gray_i = 4'h0;
    logic [3:0] output_o, binary_o;
    logic       overflow_o, underflow_o, wrap_o;

    logic       en3 = 1'b0;
    logic [2:0] out3, bin3;
    logic       ovf3, unf3, wrp3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .up_i(up_i), .load_i(load_i),
        .load_gray_i(load_gray_i), .clear_flags_i(clear_flags_i),
        .output_o(output_o), .binary_o(binary_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .wrap_o(wrap_o)
    );

    gray_updown_counter #(.WIDTH(3)) dut3 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en3), .up_i(1'b1), .load_i(1'b0),
        .load_gray_i(3'h0), .clear_flags_i(1'b0),
        .output_o(out3), .binary_o(bin3), .overflow_o(ovf3),
        .underflow_o(unf3), .wrap_o(wrp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks all five outputs of the WIDTH=4 instance at once.
    task automatic expect4(input string tag, input logic [3:0] g, input logic [3:0] b,
                           input logic o, input logic u, input logic w);
        check({tag, ".gray"}, 32'(output_o), 32'(g));
        check({tag, ".bin"},  32'(binary_o), 32'(b));
        check({tag, ".ovf"},  32'(overflow_o), 32'(o));
        check({tag, ".unf"},  32'(underflow_o), 32'(u));
        check({tag, ".wrap"}, 32'(wrap_o), 32'(w));
    endtask

    logic [3:0] gseq4 [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [2:0] gseq3 [0:8]  = '{3'h0, 3'h1, 3'h3, 3'h2, 3'h6, 3'h7, 3'h5, 3'h4, 3'h0};

    initial begin
        logic [3:0] prev4;
        logic [2:0] prev3;

        // Reset state
        #3;
        expect4("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("reset.w3gray", 32'(out3), 32'h0);
        step();
        reset_i = 1'b0;

        // Full up-count through the wrap
        en_i = 1'b1; up_i = 1'b1;
        prev4 = output_o;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("up%0d.gray", i), 32'(output_o), 32'(gseq4[i % 16]));
            check($sformatf("up%0d.bin", i), 32'(binary_o), 32'(i % 16));
            check($sformatf("up%0d.onebit", i), 32'($countones(output_o ^ prev4)), 32'd1);
            check($sformatf("up%0d.ovf", i), 32'(overflow_o), 32'(i == 16));
            check($sformatf("up%0d.wrap", i), 32'(wrap_o), 32'(i == 16));
            prev4 = output_o;
        end
        en_i = 1'b0;
        step();
        expect4("hold_after_wrap", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Async reset, then a single down-step from 0
        #2 reset_i = 1'b1;
        #1 expect4("rst2", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        reset_i = 1'b0;
        en_i = 1'b1; up_i = 1'b0;
        step();
        expect4("down_wrap", 4'h8, 4'hF, 1'b0, 1'b1, 1'b1);
        en_i = 1'b0;
        step();
        expect4("down_hold", 4'h8, 4'hF, 1'b0, 1'b1, 1'b0);

        // Load beats a simultaneous enable
        load_i = 1'b1; load_gray_i = 4'hC; en_i = 1'b1; up_i = 1'b1;
        step();
        expect4("load_c", 4'hC, 4'h8, 1'b0, 1'b1, 1'b0);
        load_i = 1'b0;
        step();
        expect4("load_c_up", 4'hD, 4'h9, 1'b0, 1'b1, 1'b0);

        // Clear flags alone
        en_i = 1'b0; clear_flags_i = 1'b1;
        step();
        expect4("clr_unf", 4'hD, 4'h9, 1'b0, 1'b0, 1'b0);
        clear_flags_i = 1'b0;

        // A load of 0 while counting down does not set underflow
        load_i = 1'b1; load_gray_i = 4'h0; en_i = 1'b1; up_i = 1'b0;
        step();
        expect4("load_0", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        load_i = 1'b0;

        // Back-to-back wraps caused by a direction flip
        step();
        expect4("flip_down", 4'h8, 4'hF, 1'b0, 1'b1, 1'b1);
        up_i = 1'b1;
        step();
        expect4("flip_up", 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // Set beats clear for the wrapping flag, and the other flag clears
        load_i = 1'b1; load_gray_i = 4'h8;
        step();
        expect4("load_8", 4'h8, 4'hF, 1'b1, 1'b1, 1'b0);
        load_i = 1'b0; clear_flags_i = 1'b1;
        step();
        expect4("clr_vs_set", 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        en_i = 1'b0;
        step();
        expect4("clr_only", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        clear_flags_i = 1'b0;

        // Async reset while the binary count is 5
        load_i = 1'b1; load_gray_i = 4'h7;
        step();
        expect4("load_7", 4'h7, 4'h5, 1'b0, 1'b0, 1'b0);
        load_i = 1'b0;
        #3 reset_i = 1'b1;
        #1 expect4("rst_mid", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        reset_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        step();
        expect4("resume", 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        en_i = 1'b0;

        // WIDTH=3 up-count through the wrap
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        en3 = 1'b1;
        prev3 = out3;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("w3_%0d.gray", i), 32'(out3), 32'(gseq3[i]));
            check($sformatf("w3_%0d.onebit", i), 32'($countones(out3 ^ prev3)), 32'd1);
            check($sformatf("w3_%0d.ovf", i), 32'(ovf3), 32'(i == 8));
            check($sformatf("w3_%0d.wrap", i), 32'(wrp3), 32'(i == 8));
            prev3 = out3;
        end
        check("w3.unf", 32'(unf3), 32'h0);
        check("w3.bin", 32'(bin3), 32'h0);
        en3 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
